// File: rtl/wb_serial_pkg.sv
// Shared register map, bit indices and UART engine state type for wb_serial_fifo.
package wb_serial_pkg;

    localparam logic [3:0] REG_DATA   = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h1;
    localparam logic [3:0] REG_CTRL   = 4'h2;
    localparam logic [3:0] REG_DIV_LO = 4'h3;
    localparam logic [3:0] REG_DIV_HI = 4'h4;

    localparam int ST_RX_AVAIL = 0;
    localparam int ST_RX_FULL  = 1;
    localparam int ST_TX_EMPTY = 2;
    localparam int ST_TX_FULL  = 3;
    localparam int ST_RX_OVF   = 4;
    localparam int ST_FRAME_ERR = 5;
    localparam int ST_TX_OVF   = 6;
    localparam int ST_TX_BUSY  = 7;

    localparam int CTRL_CLR_FLAGS = 0;
    localparam int CTRL_RX_FLUSH  = 1;
    localparam int CTRL_TX_FLUSH  = 2;
    localparam int CTRL_LOOPBACK  = 3;

    localparam logic [15:0] DIV_MIN = 16'd4;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    // The receiver samples at div/2, so tiny divisors are forced up to a sane floor.
    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; flush wins over push/pop, push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/wb_serial_fifo.sv
// Wishbone-attached 8N1 UART with TX/RX FIFOs and status/divisor registers.
// Optional internal loopback (CTRL bit3) is built when WB_SERIAL_LOOPBACK_EN is defined.
module wb_serial_fifo
    import wb_serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] wb_adr_i,
    input  logic [7:0] wb_dat_i,
    output logic [7:0] wb_dat_o,
    input  logic       wb_cyc_i,
    input  logic       wb_stb_i,
    input  logic       wb_we_i,
    output logic       wb_ack_o,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic       irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [3:0]  reg_sel;
    logic        wb_access, wb_wr, wb_rd, ctrl_wr;
    logic [7:0]  rd_data, status, ctrl_rd;
    logic [15:0] div_reg, div_eff;
    logic        rx_ovf, frame_err, tx_ovf;
    logic        unused_adr_hi;

    assign reg_sel       = wb_adr_i[3:0];
    assign unused_adr_hi = ^wb_adr_i[7:4];
    assign wb_access     = wb_cyc_i && wb_stb_i && !wb_ack_o;
    assign wb_wr         = wb_access && wb_we_i;
    assign wb_rd         = wb_access && !wb_we_i;
    assign ctrl_wr       = wb_wr && (reg_sel == REG_CTRL);
    assign div_eff       = clamp_div(div_reg);

    // FIFOs
    logic          tx_push, tx_pop, tx_flush, tx_full, tx_empty;
    logic          rx_push, rx_pop, rx_flush, rx_full, rx_empty;
    logic [7:0]    tx_head, rx_head, rx_shift;
    logic [CW-1:0] tx_count, rx_count;

    assign tx_push  = wb_wr && (reg_sel == REG_DATA);
    assign rx_pop   = wb_rd && (reg_sel == REG_DATA);
    assign tx_flush = ctrl_wr && wb_dat_i[CTRL_TX_FLUSH];
    assign rx_flush = ctrl_wr && wb_dat_i[CTRL_RX_FLUSH];

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .din(wb_dat_i), .pop(tx_pop),
        .flush(tx_flush), .dout(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .din(rx_shift), .pop(rx_pop),
        .flush(rx_flush), .dout(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    // Transmitter
    uart_state_t tx_state, tx_state_n;
    logic [15:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic [7:0]  tx_shift, tx_shift_n;
    logic        tx_end, tx_ser;

    assign tx_end = (tx_cnt == tx_div - 16'd1);
    assign tx_ser = (tx_state == START) ? 1'b0 : (tx_state == DATA) ? tx_shift[0] : 1'b1;

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + 16'd1;
        tx_div_n   = tx_div;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_pop     = 1'b0;
        case (tx_state)
            IDLE: begin
                tx_cnt_n = '0;
                if (!tx_empty && !tx_flush) begin
                    tx_pop     = 1'b1;
                    tx_shift_n = tx_head;
                    tx_div_n   = div_eff;
                    tx_state_n = START;
                end
            end
            START: if (tx_end) begin
                tx_cnt_n   = '0;
                tx_bit_n   = '0;
                tx_state_n = DATA;
            end
            DATA: if (tx_end) begin
                tx_cnt_n   = '0;
                tx_shift_n = {1'b0, tx_shift[7:1]};
                tx_bit_n   = tx_bit + 3'd1;
                if (tx_bit == 3'd7) tx_state_n = STOP;
            end
            STOP: if (tx_end) begin
                tx_cnt_n = '0;
                // Chain straight into the next start bit so queued bytes leave gap-free.
                if (!tx_empty && !tx_flush) begin
                    tx_pop     = 1'b1;
                    tx_shift_n = tx_head;
                    tx_div_n   = div_eff;
                    tx_state_n = START;
                end else begin
                    tx_state_n = IDLE;
                end
            end
            default: tx_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_div   <= 16'(CLKS_PER_BIT);
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_div   <= tx_div_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
        end
    end

    // Loopback routing
    logic rx_line;
`ifdef WB_SERIAL_LOOPBACK_EN
    logic lb_en;
    always_ff @(posedge clk) begin
        if (rst)          lb_en <= 1'b0;
        else if (ctrl_wr) lb_en <= wb_dat_i[CTRL_LOOPBACK];
    end
    assign rx_line = lb_en ? tx_ser : uart_rx;
    assign uart_tx = lb_en ? 1'b1 : tx_ser;
    assign ctrl_rd = {4'b0, lb_en, 3'b0};
`else
    assign rx_line = uart_rx;
    assign uart_tx = tx_ser;
    assign ctrl_rd = 8'h00;
`endif

    // Receiver
    uart_state_t rx_state, rx_state_n;
    logic [15:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n;
    logic [2:0]  rx_bit, rx_bit_n;
    logic [7:0]  rx_shift_n;
    logic        rx_s1, rx_s2, rx_prev, rx_end, rx_ferr;

    assign rx_end = (rx_cnt == rx_div - 16'd1);

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + 16'd1;
        rx_div_n   = rx_div;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_push    = 1'b0;
        rx_ferr    = 1'b0;
        case (rx_state)
            IDLE: begin
                rx_cnt_n = '0;
                if (rx_prev && !rx_s2) begin
                    rx_div_n   = div_eff;
                    rx_state_n = START;
                end
            end
            START: if (rx_cnt == (rx_div >> 1) - 16'd1) begin
                rx_cnt_n   = '0;
                rx_bit_n   = '0;
                rx_state_n = rx_s2 ? IDLE : DATA;
            end
            DATA: if (rx_end) begin
                rx_cnt_n   = '0;
                rx_shift_n = {rx_s2, rx_shift[7:1]};
                rx_bit_n   = rx_bit + 3'd1;
                if (rx_bit == 3'd7) rx_state_n = STOP;
            end
            STOP: if (rx_end) begin
                rx_cnt_n   = '0;
                rx_push    = rx_s2;
                rx_ferr    = !rx_s2;
                rx_state_n = IDLE;
            end
            default: rx_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_div   <= 16'(CLKS_PER_BIT);
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1    <= rx_line;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_div   <= rx_div_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    // Sticky flags and divisor; a set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ovf    <= 1'b0;
            frame_err <= 1'b0;
            tx_ovf    <= 1'b0;
            div_reg   <= 16'(CLKS_PER_BIT);
        end else begin
            if (ctrl_wr && wb_dat_i[CTRL_CLR_FLAGS]) begin
                rx_ovf    <= 1'b0;
                frame_err <= 1'b0;
                tx_ovf    <= 1'b0;
            end
            if (rx_push && rx_full && !rx_pop && !rx_flush) rx_ovf <= 1'b1;
            if (tx_push && tx_full && !tx_pop && !tx_flush) tx_ovf <= 1'b1;
            if (rx_ferr) frame_err <= 1'b1;
            if (wb_wr && reg_sel == REG_DIV_LO) div_reg[7:0]  <= wb_dat_i;
            if (wb_wr && reg_sel == REG_DIV_HI) div_reg[15:8] <= wb_dat_i;
        end
    end

    always_comb begin
        status               = 8'h00;
        status[ST_RX_AVAIL]  = (rx_count != '0);
        status[ST_RX_FULL]   = (rx_count == CW'(FIFO_DEPTH));
        status[ST_TX_EMPTY]  = (tx_count == '0);
        status[ST_TX_FULL]   = (tx_count == CW'(FIFO_DEPTH));
        status[ST_RX_OVF]    = rx_ovf;
        status[ST_FRAME_ERR] = frame_err;
        status[ST_TX_OVF]    = tx_ovf;
        status[ST_TX_BUSY]   = (tx_state != IDLE);
    end

    always_comb begin
        rd_data = 8'h00;
        case (reg_sel)
            REG_DATA:   rd_data = rx_empty ? 8'h00 : rx_head;
            REG_STATUS: rd_data = status;
            REG_CTRL:   rd_data = ctrl_rd;
            REG_DIV_LO: rd_data = div_reg[7:0];
            REG_DIV_HI: rd_data = div_reg[15:8];
            default:    rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= 8'h00;
        end else begin
            wb_ack_o <= wb_access;
            if (wb_rd) wb_dat_o <= rd_data;
        end
    end

    assign irq = (rx_count != '0);

endmodule

// File: tb/tb_wb_serial_fifo.sv
// Randomized self-checking bench for wb_serial_fifo against a queue-based model of the UART/FIFO rules.
module tb_wb_serial_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wb_adr_i = '0, wb_dat_i = '0, wb_dat_o;
    logic       wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0, wb_ack_o;
    logic       uart_rx = 1'b1, uart_tx, irq;

    int checks = 0;
    int fails  = 0;

    localparam int DEPTH = 16;
    localparam int BIT   = 16;

    always #5 clk = ~clk;

    wb_serial_fifo dut (
        .clk(clk), .rst(rst), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o),
        .uart_rx(uart_rx), .uart_tx(uart_tx), .irq(irq)
    );

    function automatic logic [7:0] exp_status(int rxn, int txn, bit rovf, bit ferr, bit tovf, bit busy);
        logic [7:0] s;
        s = 8'h00;
        s[0] = (rxn > 0);
        s[1] = (rxn == DEPTH);
        s[2] = (txn == 0);
        s[3] = (txn == DEPTH);
        s[4] = rovf;
        s[5] = ferr;
        s[6] = tovf;
        s[7] = busy;
        return s;
    endfunction

    task automatic wb_xfer(input logic [7:0] a, input logic we, input logic [7:0] d, output logic [7:0] rd);
        @(negedge clk);
        wb_adr_i = a; wb_dat_i = d; wb_we_i = we; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (wb_ack_o !== 1'b1) begin
            fails++;
            $display("FAIL ack_latency adr=%h: ack=%b expected 1", a, wb_ack_o);
        end
        rd = wb_dat_o;
        @(negedge clk);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic wb_write(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] dummy;
        wb_xfer(a, 1'b1, d, dummy);
    endtask

    task automatic wb_read(input logic [7:0] a, output logic [7:0] d);
        wb_xfer(a, 1'b0, 8'h00, d);
    endtask

    task automatic set_div(input logic [15:0] dv);
        wb_write(8'h03, dv[7:0]);
        wb_write(8'h04, dv[15:8]);
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            uart_rx = fr[i];
            repeat (BIT) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [7:0] d;
        logic [15:0] rv;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (wb_ack_o !== 1'b0 || wb_dat_o !== 8'h00 || uart_tx !== 1'b1 || irq !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: ack=%b dat=%h tx=%b irq=%b expected 0 00 1 0", wb_ack_o, wb_dat_o, uart_tx, irq);
        end
        rst = 1'b0;
        @(negedge clk);
        wb_adr_i = 8'h01; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (wb_ack_o !== 1'b1 || wb_dat_o !== 8'h04) begin
            fails++;
            $display("FAIL reset_status: ack=%b dat=%h expected 1 04", wb_ack_o, wb_dat_o);
        end
        @(posedge clk); #1;
        checks++;
        if (wb_ack_o !== 1'b0 || wb_dat_o !== 8'h04) begin
            fails++;
            $display("FAIL ack_single_cycle: ack=%b dat=%h expected 0 04", wb_ack_o, wb_dat_o);
        end
        @(negedge clk);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        rv = 16'd234;
        wb_read(8'h03, d);
        checks++;
        if (d !== rv[7:0]) begin fails++; $display("FAIL reset_div_lo: got %h expected %h", d, rv[7:0]); end
        wb_read(8'h04, d);
        checks++;
        if (d !== rv[15:8]) begin fails++; $display("FAIL reset_div_hi: got %h expected %h", d, rv[15:8]); end
        wb_write(8'h09, 8'hFF);
        wb_read(8'h07, d);
        checks++;
        if (d !== 8'h00) begin fails++; $display("FAIL unmapped_read: got %h expected 00", d); end
        wb_read(8'h21, d);
        checks++;
        if (d !== 8'h04) begin fails++; $display("FAIL adr_alias_status: got %h expected 04", d); end
    endtask

    task automatic test_tx_frame;
        logic [7:0] d, b;
        logic [9:0] fr;
        int k;
        b = 8'hA5;
        fr = {1'b1, b, 1'b0};
        set_div(16'd16);
        wb_write(8'h00, b);
        k = 0;
        @(negedge clk);
        while (uart_tx !== 1'b0 && k < 20) begin @(negedge clk); k++; end
        checks++;
        if (uart_tx !== 1'b0) begin fails++; $display("FAIL tx_start_timeout: tx=%b expected 0", uart_tx); end
        for (int c = 0; c < 10 * BIT; c++) begin
            if (c > 0) @(negedge clk);
            if ((c % BIT) == 1 || (c % BIT) == BIT - 2) begin
                checks++;
                if (uart_tx !== fr[c / BIT]) begin
                    fails++;
                    $display("FAIL tx_bit%0d_cyc%0d: tx=%b expected %b", c / BIT, c, uart_tx, fr[c / BIT]);
                end
            end
        end
        wb_read(8'h01, d);
        checks++;
        if (d !== exp_status(0, 0, 0, 0, 0, 0) || uart_tx !== 1'b1) begin
            fails++;
            $display("FAIL tx_done_status: status=%h tx=%b expected 04 1", d, uart_tx);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] bytes [3];
        logic [7:0] d;
        for (int i = 0; i < 3; i++) bytes[i] = 8'($urandom);
        fork
            begin
                int k;
                logic [9:0] got;
                k = 0;
                @(negedge clk);
                while (uart_tx !== 1'b0 && k < 40) begin @(negedge clk); k++; end
                checks++;
                if (uart_tx !== 1'b0) begin fails++; $display("FAIL b2b_start_timeout: tx=%b expected 0", uart_tx); end
                for (int j = 0; j < 3; j++) begin
                    got = '0;
                    for (int c = 0; c < 10 * BIT; c++) begin
                        if (j > 0 || c > 0) @(negedge clk);
                        if ((c % BIT) == BIT / 2) got[c / BIT] = uart_tx;
                    end
                    checks++;
                    if (got !== {1'b1, bytes[j], 1'b0}) begin
                        fails++;
                        $display("FAIL b2b_byte%0d: frame=%b expected %b", j, got, {1'b1, bytes[j], 1'b0});
                    end
                end
            end
            begin
                logic [7:0] s;
                for (int i = 0; i < 3; i++) wb_write(8'h00, bytes[i]);
                wb_read(8'h01, s);
                checks++;
                if (s !== exp_status(0, 2, 0, 0, 0, 1)) begin
                    fails++;
                    $display("FAIL b2b_busy_status: got %h expected %h", s, exp_status(0, 2, 0, 0, 0, 1));
                end
            end
        join
        repeat (4) @(negedge clk);
        wb_read(8'h01, d);
        checks++;
        if (d !== exp_status(0, 0, 0, 0, 0, 0)) begin fails++; $display("FAIL b2b_idle_status: got %h expected 04", d); end
    endtask

    task automatic test_div_clamp;
        logic [7:0] d;
        int k, low;
        set_div(16'd1);
        wb_read(8'h03, d);
        checks++;
        if (d !== 8'h01) begin fails++; $display("FAIL div_raw_readback: got %h expected 01", d); end
        wb_write(8'h00, 8'hFF);
        k = 0;
        @(negedge clk);
        while (uart_tx !== 1'b0 && k < 20) begin @(negedge clk); k++; end
        low = 0;
        while (uart_tx === 1'b0 && low < 50) begin low++; @(negedge clk); end
        checks++;
        if (low != 4) begin fails++; $display("FAIL div_clamp_start_len: got %0d cycles expected 4", low); end
        repeat (60) @(negedge clk);
        set_div(16'd16);
    endtask

    task automatic test_rx;
        logic [7:0] q[$];
        logic [7:0] d, b, e;
        bit rovf, ferr;
        rovf = 0; ferr = 0;
        drive_frame(8'h3C, 1'b1);
        q.push_back(8'h3C);
        checks++;
        if (irq !== 1'b1) begin fails++; $display("FAIL rx_irq_set: irq=%b expected 1", irq); end
        wb_read(8'h01, d);
        checks++;
        if (d !== exp_status(q.size(), 0, rovf, ferr, 0, 0)) begin
            fails++; $display("FAIL rx_avail_status: got %h expected %h", d, exp_status(q.size(), 0, rovf, ferr, 0, 0));
        end
        wb_read(8'h00, d);
        e = q.pop_front();
        checks++;
        if (d !== e) begin fails++; $display("FAIL rx_data_3c: got %h expected %h", d, e); end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin fails++; $display("FAIL rx_irq_clear: irq=%b expected 0", irq); end

        drive_frame(8'($urandom), 1'b0);
        ferr = 1;
        wb_read(8'h01, d);
        checks++;
        if (d !== exp_status(q.size(), 0, rovf, ferr, 0, 0)) begin
            fails++; $display("FAIL rx_frame_err: got %h expected %h", d, exp_status(q.size(), 0, rovf, ferr, 0, 0));
        end

        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom);
            drive_frame(b, 1'b1);
            if (q.size() < DEPTH) q.push_back(b);
            else rovf = 1;
        end
        wb_read(8'h01, d);
        checks++;
        if (d !== exp_status(q.size(), 0, rovf, ferr, 0, 0)) begin
            fails++; $display("FAIL rx_overflow_status: got %h expected %h", d, exp_status(q.size(), 0, rovf, ferr, 0, 0));
        end
        for (int i = 0; i < DEPTH; i++) begin
            wb_read(8'h00, d);
            e = q.pop_front();
            checks++;
            if (d !== e) begin fails++; $display("FAIL rx_drain_%0d: got %h expected %h", i, d, e); end
        end
        wb_read(8'h00, d);
        checks++;
        if (d !== 8'h00 || irq !== 1'b0) begin fails++; $display("FAIL rx_empty_read: got %h irq=%b expected 00 0", d, irq); end
        wb_write(8'h02, 8'h01);
        wb_read(8'h01, d);
        checks++;
        if (d !== exp_status(0, 0, 0, 0, 0, 0)) begin fails++; $display("FAIL rx_flags_cleared: got %h expected 04", d); end
    endtask

    task automatic test_tx_overflow;
        logic [7:0] d;
        int tcnt;
        bit busy, tovf;
        tcnt = 0; busy = 0; tovf = 0;
        set_div(16'hFFFF);
        for (int n = 0; n < DEPTH + 2; n++) begin
            wb_write(8'h00, 8'($urandom));
            if (tcnt < DEPTH) tcnt++;
            else tovf = 1;
            if (!busy && tcnt > 0) begin tcnt--; busy = 1; end
            if (n == 9) begin
                wb_read(8'h01, d);
                checks++;
                if (d !== exp_status(0, tcnt, 0, 0, tovf, busy)) begin
                    fails++; $display("FAIL tx_partial_fill: got %h expected %h", d, exp_status(0, tcnt, 0, 0, tovf, busy));
                end
            end
        end
        wb_read(8'h01, d);
        checks++;
        if (d !== exp_status(0, tcnt, 0, 0, tovf, busy)) begin
            fails++; $display("FAIL tx_overflow_status: got %h expected %h", d, exp_status(0, tcnt, 0, 0, tovf, busy));
        end
        wb_write(8'h02, 8'h01);
        tovf = 0;
        wb_read(8'h01, d);
        checks++;
        if (d !== exp_status(0, tcnt, 0, 0, tovf, busy)) begin
            fails++; $display("FAIL tx_ovf_clear: got %h expected %h", d, exp_status(0, tcnt, 0, 0, tovf, busy));
        end
        wb_write(8'h02, 8'h04);
        tcnt = 0;
        wb_read(8'h01, d);
        checks++;
        if (d !== exp_status(0, tcnt, 0, 0, tovf, busy) || uart_tx !== 1'b0) begin
            fails++; $display("FAIL tx_flush: status=%h tx=%b expected %h 0", d, uart_tx, exp_status(0, tcnt, 0, 0, tovf, busy));
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (uart_tx !== 1'b1) begin fails++; $display("FAIL reset_mid_frame_tx: tx=%b expected 1", uart_tx); end
        @(negedge clk);
        rst = 1'b0;
        wb_read(8'h01, d);
        checks++;
        if (d !== exp_status(0, 0, 0, 0, 0, 0)) begin fails++; $display("FAIL reset_mid_frame_status: got %h expected 04", d); end
        set_div(16'd16);
    endtask

`ifdef WB_SERIAL_LOOPBACK_EN
    task automatic test_loopback;
        logic [7:0] d;
        bit went_low;
        wb_write(8'h02, 8'h08);
        wb_read(8'h02, d);
        checks++;
        if (d !== 8'h08) begin fails++; $display("FAIL lb_ctrl_readback: got %h expected 08", d); end
        wb_write(8'h00, 8'h55);
        went_low = 0;
        repeat (12 * BIT) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) went_low = 1;
        end
        checks++;
        if (went_low) begin fails++; $display("FAIL lb_tx_held_high: line dropped, expected constant 1"); end
        wb_read(8'h00, d);
        checks++;
        if (d !== 8'h55) begin fails++; $display("FAIL lb_rx_data: got %h expected 55", d); end
        wb_write(8'h02, 8'h00);
    endtask
`else
    task automatic test_ctrl_readback;
        logic [7:0] d;
        wb_write(8'h02, 8'h08);
        wb_read(8'h02, d);
        checks++;
        if (d !== 8'h00) begin fails++; $display("FAIL ctrl_read_zero: got %h expected 00", d); end
    endtask
`endif

    initial begin
        test_reset();
        test_tx_frame();
        test_back_to_back();
        test_div_clamp();
        test_rx();
        test_tx_overflow();
`ifdef WB_SERIAL_LOOPBACK_EN
        test_loopback();
`else
        test_ctrl_readback();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
